dma_ctrl_nch: RTL and testbench
===============================

Name: dma_ctrl_nch

Overview:
Parametrised 8257-style DMA controller and successor to the fixed 4-channel K580VT57 block. It adds:
- configurable channel count
- register readback
- rotating priority
- TC-stop
- generalised autoload
- extended write

It sits between the CPU bus (slave register port) and the system bus (master side), with bus arbitration via hrq/hlda. Video DMA for the CRT controller is its primary client.

Parameters:
NCH, 4, number of channels (2..8)
IAW, 4, register address width; must satisfy 2^IAW >= 2*NCH+2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  DMA state-machine clock enable; register port ignores ce
iaddr  in  IAW  CPU register address
idata  in  8  CPU write data
odata  out  8  CPU read data (combinational from iaddr and byte flip-flop)
iwe_n  in  1  CPU write strobe, active low; acts on its rising edge
ird_n  in  1  CPU read strobe, active low; read side effects act on its rising edge
drq  in  NCH  DMA requests
hlda  in  1  hold acknowledge
hrq  out  1  hold request
dack  out  NCH  DMA acknowledge, active high, one-hot
tc  out  1  terminal-count pulse
oaddr  out  16  memory address
ord_n  out  1  memory read strobe
owe_n  out  1  memory write strobe
oiord_n  out  1  I/O read strobe
oiowe_n  out  1  I/O write strobe

Behaviour:
- One clock (clk); reset synchronous, active-high. All state updates on rising clk.
- Strobe edge detection: registered copies of iwe_n/ird_n; an edge is the cycle where the strobe is high and its copy is low.
- Register map:
  - 2k = ADDR[k], 16 bits
  - 2k+1 = CNT[k], 16 bits; [13:0] count, [15:14] type
  - 2*NCH = MODE (write: enable bits [NCH-1:0]) / STATUS (read: TC flags [NCH-1:0])
  - 2*NCH+1 = CFG: bit0 rotate, bit1 tcstop, bit2 autoload, bit3 extwr
- Byte flip-flop ff:
  - 16-bit regs use low byte at ff=0, high byte at ff=1.
  - Each write or read edge on a 16-bit reg toggles ff.
  - Any write to MODE or CFG clears ff.
- Readback: odata = selected byte of the addressed reg, or STATUS, or CFG; zero-extended; unmapped addresses read 0.
- STATUS read edge clears all TC flags. A TC set in the same cycle wins.
- Autoload write shadow: when autoload=1, writes to ch NCH-2 regs also write ch NCH-1.
- Collision rule: a CPU write in the same cycle as a DMA register update wins.
- Transfer type from CNT[15:14]:
  - 01 = write: oiord_n and owe_n asserted
  - 10 = read: ord_n and oiowe_n asserted
  - 00 and 11 = verify: no strobes
- Request gating: mdrq = drq & enable.
- State machine (advances only when ce=1):
  - IDLE: if |mdrq, go to WAIT.
  - WAIT: hrq=1. Arbitrate every ce cycle:
    - fixed: highest index wins
    - rotate: channel after the last serviced is highest
    - On hlda=1, latch the winner and go to T1. If mdrq becomes 0 before hlda, return to IDLE.
  - T1: dack[ch]=1. Read-side strobe (ord_n or oiord_n) low. Write-side strobe low only when extwr=1. Go to T2.
  - T2: read-side and write-side strobes low. Stay while drq[ch]=1. When drq[ch]=0, go to T3.
  - T3: dack=0; strobes high.
    - If count==0: set TC flag; tc=1 for this cycle.
      - If autoload and ch==NCH-2: copy ADDR and CNT[13:0] from ch NCH-1.
      - Otherwise, if tcstop: clear enable[ch].
    - Else: ADDR+1 (wraps FFFF->0000) and count-1.
    - Next state: WAIT if |mdrq else IDLE. hrq stays 1 through T3.
- hrq=1 in WAIT, T1, T2 and T3.
- A programmed count N yields N+1 transfers.
- Reset values: state IDLE; all regs, enables, CFG, flags and ff = 0; hrq=0, dack=0, tc=0, all strobes 1, oaddr=0, odata=0.
- Reset mid-transfer aborts the cycle: strobes and dack deassert on the next clk.
- Disabling the active channel mid-transfer completes the current byte, then returns to IDLE or WAIT.

Test Plan:
- Program ch0 ADDR=1234h, CNT=8002h (read, 3 bytes); pulse drq0 three times with hlda held high -> oaddr 1234h, 1235h, 1236h; ord_n and oiowe_n low in T2; tc pulses after the 3rd; STATUS reads 01h, then 00h on the next read.
- Readback: write ADDR1 = 5Ah, A5h -> two reads return 5Ah, A5h. A MODE write mid-sequence resets ff.
- Priority: drq1 and drq3 asserted continuously, rotate=0 -> dack3 serviced repeatedly. With rotate=1 -> services alternate 3, 1, 3, 1.
- Autoload (NCH=4): CFG=04h; write ch2 ADDR=E000h, CNT=4001h (ch3 shadowed); then ch3 ADDR=F000h. After ch2 TC -> ch2 ADDR=F000h, count=0001h; flag bit2 set.
- tcstop=1, extwr=1, write type: owe_n low in T1 and T2. After TC, enable[ch] clears and further drq is ignored (hrq stays 0).
- Assert reset in T2 -> next cycle hrq=0, dack=0, strobes 1, regs 0. Also check hlda delayed by 5 ce cycles -> state held in WAIT with hrq=1.

Source files
------------

// File: rtl/dma_ctrl_nch.sv
// Parametrised 8257-style DMA controller with NCH channels, register readback,
// rotating priority, TC-stop, generalised autoload and extended write.
// CPU register port on one side, system-bus master strobes on the other,
// bus ownership negotiated through hrq/hlda.
module dma_ctrl_nch #(
  parameter int NCH = 4,
  parameter int IAW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  input  logic [IAW-1:0] iaddr,
  input  logic [7:0]     idata,
  output logic [7:0]     odata,
  input  logic           iwe_n,
  input  logic           ird_n,
  input  logic [NCH-1:0] drq,
  input  logic           hlda,
  output logic           hrq,
  output logic [NCH-1:0] dack,
  output logic           tc,
  output logic [15:0]    oaddr,
  output logic           ord_n,
  output logic           owe_n,
  output logic           oiord_n,
  output logic           oiowe_n
);

  localparam int CW = $clog2(NCH);
  localparam logic [IAW-1:0] MODE_A = IAW'(2 * NCH);
  localparam logic [IAW-1:0] CFG_A  = IAW'(2 * NCH + 1);
  // Autoload pair: channel NCH-2 reloads from channel NCH-1.
  localparam logic [CW-1:0]  AL_CH  = CW'(NCH - 2);
  localparam logic [CW-1:0]  AL_SRC = CW'(NCH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_T1, S_T2, S_T3} state_t;

  // Packed MSB-first, so rotate lands on bit 0 of the CFG byte.
  typedef struct packed {
    logic extwr;
    logic autoload;
    logic tcstop;
    logic rotate;
  } cfg_t;

  state_t         state, state_nx;
  cfg_t           cfg;
  logic [15:0]    addr_q [NCH];
  logic [15:0]    cnt_q  [NCH];
  logic [NCH-1:0] enable;
  logic [NCH-1:0] tc_flag;
  logic [NCH-1:0] mdrq;
  logic           ff;
  logic           iwe_q, ird_q;
  logic           we_edge, rd_edge;
  logic           is_reg16, is_cnt;
  logic [CW-1:0]  reg_ch;
  logic [CW-1:0]  ch_q, last_ch, win;
  logic           count_zero;
  logic           rd_side, wr_side;
  logic [1:0]     xtype;
  logic [15:0]    rd_sel;

  assign we_edge    = iwe_n & ~iwe_q;
  assign rd_edge    = ird_n & ~ird_q;
  assign is_reg16   = (iaddr < MODE_A);
  assign is_cnt     = iaddr[0];
  assign reg_ch     = CW'(iaddr >> 1);
  assign mdrq       = drq & enable;
  assign count_zero = (cnt_q[ch_q][13:0] == 14'd0);

  // Registered strobe copies for rising-edge detection.
  // NOTE: the copies reset high so an idle-high strobe right after reset is
  // not mistaken for a completed CPU access.
  always_ff @(posedge clk) begin
    if (reset) begin
      iwe_q <= 1'b1;
      ird_q <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      iwe_q <= iwe_n;
      ird_q <= ird_n;
    end
  end

  // CPU readback mux: byte of a 16-bit register, STATUS or CFG; else zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    odata  = 8'h00;
    rd_sel = 16'h0000;
    if (is_reg16) begin
      rd_sel = is_cnt ? cnt_q[reg_ch] : addr_q[reg_ch];
      odata  = ff ? rd_sel[15:8] : rd_sel[7:0];
    end else if (iaddr == MODE_A) begin
      odata = 8'(tc_flag);
    end else if (iaddr == CFG_A) begin
      odata = {4'h0, cfg};
    end
  end

  // Arbiter: fixed favours the highest index; rotating starts just after the
  // last serviced channel and walks upward with wrap.
  always_comb begin
    win = '0;
    if (cfg.rotate) begin
      for (int i = NCH; i >= 1; i--) begin
        if (mdrq[(int'(last_ch) + i) % NCH]) win = CW'((int'(last_ch) + i) % NCH);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (mdrq[i]) win = CW'(i);
      end
    end
  end

  // Transfer state register, advanced only on ce.
  always_ff @(posedge clk) begin
    if (reset)   state <= S_IDLE;
    else if (ce) state <= state_nx;
  end

  // Next-state and bus-side outputs.
  always_comb begin
    state_nx = state;
    hrq      = (state != S_IDLE);
    dack     = '0;
    rd_side  = 1'b0;
    wr_side  = 1'b0;
    oaddr    = 16'h0000;
    xtype    = cnt_q[ch_q][15:14];
    tc       = (state == S_T3) && count_zero;
    case (state)
      S_IDLE: if (|mdrq) state_nx = S_WAIT;
      S_WAIT: begin
        if (!(|mdrq))  state_nx = S_IDLE;
        else if (hlda) state_nx = S_T1;
      end
      S_T1: begin
        dack[ch_q] = 1'b1;
        rd_side    = 1'b1;
        wr_side    = cfg.extwr;
        oaddr      = addr_q[ch_q];
        state_nx   = S_T2;
      end
      S_T2: begin
        dack[ch_q] = 1'b1;
        rd_side    = 1'b1;
        wr_side    = 1'b1;
        oaddr      = addr_q[ch_q];
        if (!drq[ch_q]) state_nx = S_T3;
      end
      S_T3: begin
        oaddr    = addr_q[ch_q];
        state_nx = (|mdrq) ? S_WAIT : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // 01 = write (I/O -> memory), 10 = read (memory -> I/O), else verify.
    ord_n   = ~(rd_side && xtype == 2'b10);
    oiowe_n = ~(wr_side && xtype == 2'b10);
    oiord_n = ~(rd_side && xtype == 2'b01);
    owe_n   = ~(wr_side && xtype == 2'b01);
  end

  // Latch the arbitration winner when the bus is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q    <= '0;
      last_ch <= '0;
    end else if (ce && state == S_WAIT && (|mdrq) && hlda) begin
      ch_q    <= win;
      last_ch <= win;
    end
  end

  // Register file, enables, TC flags, CFG and byte flip-flop. Later
  // statements win: TC set beats STATUS clear, CPU write beats DMA update.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array is plain flops, not RAM, and readback must
      // show zeros after reset, so every entry is cleared here.
      for (int k = 0; k < NCH; k++) begin
        addr_q[k] <= 16'h0000;
        cnt_q[k]  <= 16'h0000;
      end
      enable  <= '0;
      tc_flag <= '0;
      cfg     <= '0;
      ff      <= 1'b0;
    end else begin
      if (rd_edge && iaddr == MODE_A) tc_flag <= '0;

      if (ce && state == S_T3) begin
        if (count_zero) begin
          tc_flag[ch_q] <= 1'b1;
          if (cfg.autoload && ch_q == AL_CH) begin
            addr_q[AL_CH]      <= addr_q[AL_SRC];
            cnt_q[AL_CH][13:0] <= cnt_q[AL_SRC][13:0];
          end else if (cfg.tcstop) begin
            enable[ch_q] <= 1'b0;
          end
        end else begin
          addr_q[ch_q]      <= addr_q[ch_q] + 16'd1;
          cnt_q[ch_q][13:0] <= cnt_q[ch_q][13:0] - 14'd1;
        end
      end

      if (we_edge) begin
        if (is_reg16) begin
          ff <= ~ff;
          for (int k = 0; k < NCH; k++) begin
            if (CW'(k) == reg_ch ||
                (cfg.autoload && reg_ch == AL_CH && CW'(k) == AL_SRC)) begin
              if (is_cnt) begin
                if (ff) cnt_q[k][15:8] <= idata;
                else    cnt_q[k][7:0]  <= idata;
              end else begin
                if (ff) addr_q[k][15:8] <= idata;
                else    addr_q[k][7:0]  <= idata;
              end
            end
          end
        end else if (iaddr == MODE_A) begin
          enable <= idata[NCH-1:0];
          ff     <= 1'b0;
        end else if (iaddr == CFG_A) begin
          cfg <= cfg_t'(idata[3:0]);
          ff  <= 1'b0;
        end
      end else if (rd_edge && is_reg16) begin
        ff <= ~ff;
      end
    end
  end

endmodule

// File: tb/tb_dma_ctrl_nch.sv
// Scoreboard bench for dma_ctrl_nch (NCH=4): stimulus queues expected
// transfers and read data; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_dma_ctrl_nch;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [3:0]  iaddr;
  logic [7:0]  idata, odata;
  logic        iwe_n, ird_n;
  logic [3:0]  drq;
  logic        hlda, hrq;
  logic [3:0]  dack;
  logic        tc;
  logic [15:0] oaddr;
  logic        ord_n, owe_n, oiord_n, oiowe_n;
  logic [3:0]  strb;

  // Strobe vector order: {ord_n, owe_n, oiord_n, oiowe_n}.
  localparam logic [3:0] RD_T1  = 4'b0111;
  localparam logic [3:0] RD_T2  = 4'b0110;
  localparam logic [3:0] WR_T1  = 4'b1101;
  localparam logic [3:0] WR_T2  = 4'b1001;
  localparam logic [3:0] WRX_T1 = 4'b1001;

  typedef struct {
    logic [3:0]  dack;
    logic [15:0] addr;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        tc;
  } xfer_t;

  xfer_t      xfer_q[$];
  logic [7:0] read_q[$];
  xfer_t      cur;
  int         checks = 0;
  int         errors = 0;
  int         phase  = 0;
  logic [3:0] dack_prev = 4'h0;

  assign strb = {ord_n, owe_n, oiord_n, oiowe_n};

  dma_ctrl_nch #(.NCH(4), .IAW(4)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .iaddr(iaddr), .idata(idata), .odata(odata),
    .iwe_n(iwe_n), .ird_n(ird_n),
    .drq(drq), .hlda(hlda), .hrq(hrq), .dack(dack), .tc(tc),
    .oaddr(oaddr), .ord_n(ord_n), .owe_n(owe_n),
    .oiord_n(oiord_n), .oiowe_n(oiowe_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read data while ird_n is low; transfers keyed on dack rising.
  always @(negedge clk) begin
    if (reset) begin
      phase = 0;
    end else begin
      if (!ird_n) begin
        if (read_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: odata %0h with nothing queued", odata);
        end else begin
          check("read_data", odata, read_q.pop_front());
        end
      end
      if (dack != 4'h0 && dack_prev == 4'h0) begin
        if (xfer_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: dack %b addr %0h", dack, oaddr);
          phase = 0;
        end else begin
          cur = xfer_q.pop_front();
          check("t1_dack", dack, cur.dack);
          check("t1_addr", oaddr, cur.addr);
          check("t1_strobes", strb, cur.s1);
          phase = 1;
        end
      end else if (phase == 1) begin
        check("t2_dack", dack, cur.dack);
        check("t2_strobes", strb, cur.s2);
        phase = 2;
      end else if (phase == 2 && dack == 4'h0) begin
        check("t3_tc", tc, cur.tc);
        check("t3_hrq", hrq, 1'b1);
        check("t3_strobes", strb, 4'hF);
        phase = 0;
      end
    end
    dack_prev = dack;
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    iaddr = a; idata = d; iwe_n = 1'b0;
    @(posedge clk); #1;
    iwe_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    read_q.push_back(exp);
    @(posedge clk); #1;
    iaddr = a; ird_n = 1'b0;
    @(posedge clk); #1;
    ird_n = 1'b1;
  endtask

  task automatic expect_xfer(input int ch, input logic [15:0] a, input logic [3:0] s1,
                             input logic [3:0] s2, input logic t);
    xfer_t x;
    x.dack = 4'(1 << ch);
    x.addr = a; x.s1 = s1; x.s2 = s2; x.tc = t;
    xfer_q.push_back(x);
  endtask

  task automatic wait_dack(input logic [3:0] mask, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if ((dack & mask) != 4'h0) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL dack_timeout: mask %b got dack %b", mask, dack);
    end
  endtask

  // One byte on channel ch: raise drq, drop it once acknowledged.
  task automatic pulse(input int ch);
    logic ok;
    @(posedge clk); #1;
    drq[ch] = 1'b1;
    wait_dack(4'(1 << ch), ok);
    drq[ch] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // One service of the priority test: expected channel ch drops its request
  // for this byte and re-raises it unless this is the final service.
  task automatic service(input int ch, input bit last);
    logic ok;
    wait_dack(4'b1010, ok);
    if (last) drq = 4'h0;
    else      drq[ch] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (!last) drq[ch] = 1'b1;
    else repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    reset = 1'b1; ce = 1'b1; iaddr = 4'h0; idata = 8'h00;
    iwe_n = 1'b1; ird_n = 1'b1; drq = 4'h0; hlda = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_hrq", hrq, 1'b0);
    check("rst_dack", dack, 4'h0);
    check("rst_tc", tc, 1'b0);
    check("rst_strobes", strb, 4'hF);
    check("rst_oaddr", oaddr, 16'h0000);
    check("rst_odata", odata, 8'h00);
    hlda = 1'b1;

    // Channel 0 read transfer, count 2 -> three bytes, tc on the last.
    wr(4'd0, 8'h34); wr(4'd0, 8'h12);
    wr(4'd1, 8'h02); wr(4'd1, 8'h80);
    wr(4'd8, 8'h01);
    expect_xfer(0, 16'h1234, RD_T1, RD_T2, 1'b0);
    expect_xfer(0, 16'h1235, RD_T1, RD_T2, 1'b0);
    expect_xfer(0, 16'h1236, RD_T1, RD_T2, 1'b1);
    pulse(0); pulse(0); pulse(0);
    rd(4'd8, 8'h01);
    rd(4'd8, 8'h00);
    rd(4'd0, 8'h36); rd(4'd0, 8'h12);
    rd(4'd1, 8'h00); rd(4'd1, 8'h80);

    // Readback and byte flip-flop clearing by MODE and CFG writes.
    wr(4'd2, 8'h5A); wr(4'd2, 8'hA5);
    rd(4'd2, 8'h5A); rd(4'd2, 8'hA5);
    wr(4'd2, 8'h11);
    wr(4'd8, 8'h01);
    wr(4'd2, 8'h22); wr(4'd2, 8'hB6);
    rd(4'd2, 8'h22);
    wr(4'd9, 8'h00);
    rd(4'd2, 8'h22);
    rd(4'd12, 8'h00);
    rd(4'd2, 8'hB6);
    rd(4'd9, 8'h00);

    // Priority: ch1 read from B622, ch3 write from 3000.
    wr(4'd3, 8'h10); wr(4'd3, 8'h80);
    wr(4'd6, 8'h00); wr(4'd6, 8'h30);
    wr(4'd7, 8'h10); wr(4'd7, 8'h40);
    wr(4'd8, 8'h0A);
    wr(4'd9, 8'h00);
    expect_xfer(3, 16'h3000, WR_T1, WR_T2, 1'b0);
    expect_xfer(3, 16'h3001, WR_T1, WR_T2, 1'b0);
    expect_xfer(3, 16'h3002, WR_T1, WR_T2, 1'b0);
    @(posedge clk); #1;
    drq = 4'b1010;
    service(3, 1'b0); service(3, 1'b0); service(3, 1'b1);
    // Rotating after ch3 was last: 1, 3, 1, 3.
    wr(4'd9, 8'h01);
    expect_xfer(1, 16'hB622, RD_T1, RD_T2, 1'b0);
    expect_xfer(3, 16'h3003, WR_T1, WR_T2, 1'b0);
    expect_xfer(1, 16'hB623, RD_T1, RD_T2, 1'b0);
    expect_xfer(3, 16'h3004, WR_T1, WR_T2, 1'b0);
    @(posedge clk); #1;
    drq = 4'b1010;
    service(1, 1'b0); service(3, 1'b0); service(1, 1'b0); service(3, 1'b1);

    // Autoload: ch2 shadowed into ch3, then ch3 address retargeted.
    wr(4'd9, 8'h04);
    wr(4'd4, 8'h00); wr(4'd4, 8'hE0);
    wr(4'd5, 8'h01); wr(4'd5, 8'h40);
    wr(4'd6, 8'h00); wr(4'd6, 8'hF0);
    wr(4'd8, 8'h04);
    expect_xfer(2, 16'hE000, WR_T1, WR_T2, 1'b0);
    expect_xfer(2, 16'hE001, WR_T1, WR_T2, 1'b1);
    pulse(2); pulse(2);
    rd(4'd4, 8'h00); rd(4'd4, 8'hF0);
    rd(4'd5, 8'h01); rd(4'd5, 8'h40);
    rd(4'd8, 8'h04);
    expect_xfer(2, 16'hF000, WR_T1, WR_T2, 1'b0);
    pulse(2);

    // TC-stop with extended write on ch0.
    wr(4'd9, 8'h0A);
    wr(4'd0, 8'h00); wr(4'd0, 8'h50);
    wr(4'd1, 8'h01); wr(4'd1, 8'h40);
    wr(4'd8, 8'h01);
    expect_xfer(0, 16'h5000, WRX_T1, WR_T2, 1'b0);
    expect_xfer(0, 16'h5001, WRX_T1, WR_T2, 1'b1);
    pulse(0); pulse(0);
    rd(4'd8, 8'h01);
    @(posedge clk); #1;
    drq[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("tcstop_hrq", hrq, 1'b0);
    end
    drq[0] = 1'b0;

    // Delayed hlda holds WAIT; ce low freezes it even with hlda.
    wr(4'd9, 8'h00);
    wr(4'd8, 8'h02);
    hlda = 1'b0;
    @(posedge clk); #1;
    drq[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("wait_hrq", hrq, 1'b1);
      check("wait_dack", dack, 4'h0);
    end
    ce = 1'b0; hlda = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ce_hold_dack", dack, 4'h0);
    end
    expect_xfer(1, 16'hB624, RD_T1, RD_T2, 1'b0);
    ce = 1'b1;
    wait_dack(4'b0010, ok);
    drq[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset during T2 aborts the cycle and clears the registers.
    expect_xfer(1, 16'hB625, RD_T1, RD_T2, 1'b0);
    drq[1] = 1'b1;
    wait_dack(4'b0010, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_hrq", hrq, 1'b0);
    check("abort_dack", dack, 4'h0);
    check("abort_strobes", strb, 4'hF);
    check("abort_tc", tc, 1'b0);
    check("abort_oaddr", oaddr, 16'h0000);
    drq = 4'h0;
    reset = 1'b0;
    rd(4'd2, 8'h00); rd(4'd3, 8'h00);
    rd(4'd9, 8'h00); rd(4'd8, 8'h00);
    repeat (3) @(posedge clk);
    #1;

    check("xfer_q_left", xfer_q.size(), 0);
    check("read_q_left", read_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
